// File: rtl/jt51_pkg.sv
// jt51_pkg: shared slot geometry, operator indices and CSM state encoding
package jt51_pkg;
  localparam int SLOT_W = 5;
  localparam int NUM_SLOTS = 32;
  localparam logic [1:0] OP_M1 = 2'd0;
  localparam logic [1:0] OP_M2 = 2'd1;
  localparam logic [1:0] OP_C1 = 2'd2;
  localparam logic [1:0] OP_C2 = 2'd3;
  typedef enum logic [1:0] {CSM_IDLE, CSM_ARMED, CSM_FORCE} csm_state_t;
  // mask bit order in the register is {C2,M2,C1,M1}
  function automatic logic [1:0] mask_op(input int b);
    return b == 0 ? OP_M1 : b == 1 ? OP_C1 : b == 2 ? OP_M2 : OP_C2;
  endfunction
endpackage

// File: rtl/jt51_kon_sched_if.sv
// jt51_kon_sched_if: key-on register bus and slot-ordered key-on stream
interface jt51_kon_sched_if;
  import jt51_pkg::*;
  logic cen;
  logic kon_we;
  logic [6:0] kon_din;
  logic csm;
  logic overflow_a;
  logic [SLOT_W-1:0] slot_II;
  logic keyon_II;
  logic zero;
  logic kon_pending;
  modport master(output cen, kon_we, kon_din, csm, overflow_a, input slot_II, keyon_II, zero, kon_pending);
  modport slave(input cen, kon_we, kon_din, csm, overflow_a, output slot_II, keyon_II, zero, kon_pending);
endinterface

// File: rtl/jt51_kon_csm.sv
// jt51_kon_csm: timer-A CSM key-on, forcing whole frames after an overflow
module jt51_kon_csm
  import jt51_pkg::*;
#(
  parameter int CSM_FRAMES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic wrap,
  input  logic overflow_a,
  input  logic csm,
  output logic csm_force
);
  csm_state_t st, st_nx;
  logic [2:0] cnt, cnt_nx;
  logic rearm, rearm_nx;
  logic ov;
  assign ov = cen & overflow_a & csm;
  always_ff @(posedge clk)
    if (rst) begin
      st <= CSM_IDLE;
      cnt <= '0;
      rearm <= 1'b0;
    end else if (cen) begin
      st <= st_nx;
      cnt <= cnt_nx;
      rearm <= rearm_nx;
    end
  // csm_force is the look-ahead value for the slot being loaded this cen
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    rearm_nx = rearm;
    case (st)
      CSM_IDLE: if (ov) st_nx = CSM_ARMED;
      CSM_ARMED:
        if (wrap) begin
          st_nx = CSM_FORCE;
          cnt_nx = 3'(CSM_FRAMES);
          rearm_nx = ov;
        end
      CSM_FORCE:
        if (wrap) begin
          rearm_nx = ov;
          if (rearm) cnt_nx = 3'(CSM_FRAMES);
          else begin
            cnt_nx = cnt - 3'd1;
            if (cnt == 3'd1) st_nx = ov ? CSM_ARMED : CSM_IDLE;
          end
        end else if (ov) rearm_nx = 1'b1;
      default: st_nx = CSM_IDLE;
    endcase
    csm_force = st_nx == CSM_FORCE;
  end
endmodule

// File: rtl/jt51_kon_sched.sv
// jt51_kon_sched: frame-committed key-on state streamed to the EG in slot order
module jt51_kon_sched
  import jt51_pkg::*;
#(
  parameter int CSM_FRAMES = 1
) (
  input logic clk,
  input logic rst,
  jt51_kon_sched_if.slave bus
);
  logic [NUM_SLOTS-1:0] kon_reg, kon_nx;
  logic [3:0] pend [8];
  logic [7:0] valid, valid_nx;
  logic [SLOT_W-1:0] slot_nx;
  logic wrap, csm_force;
  assign wrap = bus.cen && bus.slot_II == SLOT_W'(NUM_SLOTS - 1);
  assign slot_nx = bus.slot_II + SLOT_W'(1);
  jt51_kon_csm #(.CSM_FRAMES(CSM_FRAMES)) u_csm (
    .clk,
    .rst,
    .cen(bus.cen),
    .wrap,
    .overflow_a(bus.overflow_a),
    .csm(bus.csm),
    .csm_force
  );
  // commit uses pending contents from before a same-cycle write
  always_comb begin
    kon_nx = kon_reg;
    valid_nx = wrap ? '0 : valid;
    if (wrap)
      for (int c = 0; c < 8; c++)
        if (valid[c])
          for (int b = 0; b < 4; b++) kon_nx[{mask_op(b), 3'(c)}] = pend[c][b];
    if (bus.cen && bus.kon_we) valid_nx[bus.kon_din[2:0]] = 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus.slot_II <= '0;
      bus.keyon_II <= 1'b0;
      bus.zero <= 1'b0;
      bus.kon_pending <= 1'b0;
      kon_reg <= '0;
      valid <= '0;
    end else if (bus.cen) begin
      bus.slot_II <= slot_nx;
      bus.keyon_II <= kon_nx[slot_nx] | csm_force;
      bus.zero <= slot_nx == '0;
      bus.kon_pending <= |valid_nx;
      kon_reg <= kon_nx;
      valid <= valid_nx;
      if (bus.kon_we) pend[bus.kon_din[2:0]] <= bus.kon_din[6:3];
    end
endmodule

// File: tb/tb_jt51_kon_sched.sv
// tb_jt51_kon_sched: randomized and directed checks against a frame-level key-on model
module tb_jt51_kon_sched;
  localparam int N = 1;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  jt51_kon_sched_if bus();
  jt51_kon_sched #(.CSM_FRAMES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt = 0, total = 0;
  bit m_kon[32];
  bit [3:0] m_pend[8];
  bit [7:0] m_val;
  int m_slot, m_left;
  bit m_zero, m_armed, csm_lvl;
  int op_of[4] = '{0, 2, 1, 3};

  task automatic model_reset();
    foreach (m_kon[i]) m_kon[i] = 0;
    m_val = 0;
    m_slot = 0;
    m_zero = 0;
    m_armed = 0;
    m_left = 0;
  endtask

  function automatic logic [7:0] exp_vec();
    return {m_slot[4:0], m_kon[m_slot] | (m_left > 0), m_zero, m_val != 0};
  endfunction

  function automatic logic [7:0] obs();
    return {bus.slot_II, bus.keyon_II, bus.zero, bus.kon_pending};
  endfunction

  task automatic tick(input bit c, input bit we, input logic [6:0] din, input bit cs, input bit ov);
    bus.cen = c;
    bus.kon_we = we;
    bus.kon_din = din;
    bus.csm = cs;
    bus.overflow_a = ov;
    @(posedge clk);
    if (rst) model_reset();
    else if (c) begin
      if (m_slot == 31) begin
        for (int ch = 0; ch < 8; ch++)
          if (m_val[ch]) for (int b = 0; b < 4; b++) m_kon[op_of[b] * 8 + ch] = m_pend[ch][b];
        m_val = 0;
        if (m_armed) begin
          m_left = N;
          m_armed = 0;
        end else if (m_left > 0) m_left--;
      end
      if (we) begin
        m_pend[din[2:0]] = din[6:3];
        m_val[din[2:0]] = 1;
      end
      if (ov && cs) m_armed = 1;
      m_slot = (m_slot + 1) % 32;
      m_zero = m_slot == 0;
    end
    @(negedge clk);
    bus.kon_we = 0;
    bus.overflow_a = 0;
  endtask

  task automatic goto(input int s);
    for (int i = 0; i < 32 && m_slot != s; i++) tick(1, 0, 7'd0, csm_lvl, 0);
  endtask

  task automatic test_reset();
    rst = 1;
    tick(1, 0, 7'd0, 0, 0);
    tick(1, 0, 7'd0, 0, 0);
    rst = 0;
    total++;
    if (obs() !== 8'h00) $display("FAIL reset: got %h expected 00", obs());
    else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      tick(1, 0, 7'd0, 0, 0);
      total++;
      if (obs() !== exp_vec() || bus.keyon_II !== 1'b0)
        $display("FAIL freerun: got %h expected %h", obs(), exp_vec());
      else pass_cnt++;
    end
  endtask

  task automatic test_write_basic();
    goto(10);
    tick(1, 1, 7'b1111_011, csm_lvl, 0);
    total++;
    if (bus.kon_pending !== 1'b1) $display("FAIL pending_set: got %b expected 1", bus.kon_pending);
    else pass_cnt++;
    goto(0);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (bus.keyon_II !== (m_slot % 8 == 3) || bus.kon_pending !== 1'b0 || obs() !== exp_vec())
        $display("FAIL write_ch3 slot %0d: got %h expected %h", m_slot, obs(), exp_vec());
      else pass_cnt++;
      tick(1, 0, 7'd0, csm_lvl, 0);
    end
  endtask

  task automatic test_last_wins();
    goto(4);
    tick(1, 1, {4'b0001, 3'd2}, csm_lvl, 0);
    tick(1, 1, {4'b1000, 3'd2}, csm_lvl, 0);
    goto(0);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (obs() !== exp_vec()) $display("FAIL last_wins slot %0d: got %h expected %h", m_slot, obs(), exp_vec());
      else pass_cnt++;
      if (m_slot == 2 || m_slot == 26) begin
        total++;
        if (bus.keyon_II !== (m_slot == 26)) $display("FAIL last_wins_bit slot %0d: got %b", m_slot, bus.keyon_II);
        else pass_cnt++;
      end
      tick(1, 0, 7'd0, csm_lvl, 0);
    end
  endtask

  task automatic test_wrap_write();
    goto(31);
    tick(1, 1, {4'b1111, 3'd5}, csm_lvl, 0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 32; i++) begin
        total++;
        if (obs() !== exp_vec()) $display("FAIL wrap_write slot %0d: got %h expected %h", m_slot, obs(), exp_vec());
        else pass_cnt++;
        if (m_slot % 8 == 5) begin
          total++;
          if (bus.keyon_II !== (f == 1)) $display("FAIL wrap_write_bit f%0d slot %0d: got %b", f, m_slot, bus.keyon_II);
          else pass_cnt++;
        end
        tick(1, 0, 7'd0, csm_lvl, 0);
      end
  endtask

  task automatic clear_all();
    goto(0);
    for (int ch = 0; ch < 8; ch++) tick(1, 1, {4'b0000, 3'(ch)}, csm_lvl, 0);
    goto(0);
  endtask

  task automatic test_csm();
    int cnt;
    clear_all();
    csm_lvl = 1;
    goto(7);
    tick(1, 0, 7'd0, 1, 1);
    goto(0);
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
        total++;
        if (obs() !== exp_vec()) $display("FAIL csm slot %0d: got %h expected %h", m_slot, obs(), exp_vec());
        else pass_cnt++;
        cnt += int'(bus.keyon_II);
        tick(1, 0, 7'd0, csm_lvl, 0);
      end
      total++;
      if (cnt !== (f == 0 ? 32 : 0)) $display("FAIL csm_frame%0d: got %0d keyons expected %0d", f, cnt, f == 0 ? 32 : 0);
      else pass_cnt++;
    end
    csm_lvl = 0;
  endtask

  task automatic test_back_to_back();
    int cnt;
    csm_lvl = 1;
    goto(7);
    tick(1, 0, 7'd0, 1, 1);
    goto(0);
    for (int f = 0; f < 3; f++) begin
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
        total++;
        if (obs() !== exp_vec()) $display("FAIL b2b slot %0d: got %h expected %h", m_slot, obs(), exp_vec());
        else pass_cnt++;
        cnt += int'(bus.keyon_II);
        tick(1, 0, 7'd0, csm_lvl, f == 0 && m_slot == 12);
      end
      total++;
      if (cnt !== (f < 2 ? 32 : 0)) $display("FAIL b2b_frame%0d: got %0d keyons expected %0d", f, cnt, f < 2 ? 32 : 0);
      else pass_cnt++;
    end
    goto(3);
    tick(1, 0, 7'd0, 1, 1);
    goto(0);
    goto(16);
    total++;
    if (bus.keyon_II !== 1'b1) $display("FAIL force_before_rst: got %b expected 1", bus.keyon_II);
    else pass_cnt++;
    rst = 1;
    tick(1, 0, 7'd0, 1, 0);
    rst = 0;
    total++;
    if (bus.slot_II !== 5'd0 || bus.keyon_II !== 1'b0 || obs() !== exp_vec())
      $display("FAIL rst_mid_force: got %h expected %h", obs(), exp_vec());
    else pass_cnt++;
    csm_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1, 0, 7'd0, 0, 0);
      total++;
      if (obs() !== exp_vec()) $display("FAIL after_rst slot %0d: got %h expected %h", m_slot, obs(), exp_vec());
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) csm_lvl = 1'($urandom_range(0, 1));
      rst = $urandom_range(0, 499) == 0;
      tick($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, 7'($urandom), csm_lvl, $urandom_range(0, 49) == 0);
      total++;
      if (obs() !== exp_vec()) $display("FAIL random %0d: got %h expected %h", i, obs(), exp_vec());
      else pass_cnt++;
    end
    rst = 0;
  endtask

  initial begin
    csm_lvl = 0;
    model_reset();
    test_reset();
    test_write_basic();
    test_last_wins();
    test_wrap_write();
    test_csm();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
